// File: rtl/cpu_mem_port.sv
// rtl/cpu_mem_port.sv - CPU data-access responder routing MEM-stage accesses to data RAM or sprite OAM
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_read/mem_write/oam_write decoder access strobes, held by the pipeline until DONE
//   addr, wdata                 access address and write data
//   stall                       combinational pipeline hold
//   rdata, rdata_valid          registered read data and its one-cycle valid pulse
//   err                         one-cycle pulse: illegal strobe combination or RAM timeout
//   ram_req/ram_we/ram_addr/ram_wdata/ram_ack/ram_rdata   data RAM req/ack handshake
//   oam_busy, oam_we, oam_addr, oam_wdata                 sprite OAM write port

module cpu_mem_port #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int OAM_ADDR_W = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  oam_write,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  stall,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rdata_valid,
    output logic                  err,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic                  ram_ack,
    input  logic [DATA_W-1:0]     ram_rdata,
    input  logic                  oam_busy,
    output logic                  oam_we,
    output logic [OAM_ADDR_W-1:0] oam_addr,
    output logic [DATA_W-1:0]     oam_wdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_REQ  = 2'd1,
        OAM_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_read;
    logic             req;
    logic             multi;

    assign req   = mem_read | mem_write | oam_write;
    assign multi = (mem_read & mem_write) | (mem_read & oam_write) | (mem_write & oam_write);

    // Stall is gated by rst_n so the pipeline is released the instant reset
    // asserts, even while the decoder still holds its strobes.
    assign stall = rst_n & (((state == IDLE) & req) | (state == RAM_REQ) | (state == OAM_WAIT));

    // Combinational so that oam_busy rising in the same cycle defers the write.
    assign oam_we = (state == OAM_WAIT) & ~oam_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_read     <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            ram_req     <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            oam_addr    <= '0;
            oam_wdata   <= '0;
        end else begin
            err         <= 1'b0;
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        ram_addr  <= addr;
                        ram_wdata <= wdata;
                        oam_addr  <= addr[OAM_ADDR_W-1:0];
                        oam_wdata <= wdata;
                        err       <= multi;
                        cnt       <= '0;
                        // Priority: oam_write > mem_write > mem_read.
                        if (oam_write) begin
                            op_read <= 1'b0;
                            state   <= OAM_WAIT;
                        end else begin
                            op_read <= ~mem_write;
                            ram_req <= 1'b1;
                            ram_we  <= mem_write;
                            state   <= RAM_REQ;
                        end
                    end
                end
                RAM_REQ: begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        ram_we  <= 1'b0;
                        if (op_read) begin
                            rdata       <= ram_rdata;
                            rdata_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Abort: a timed-out read still completes, with zero data.
                        ram_req <= 1'b0;
                        ram_we  <= 1'b0;
                        err     <= 1'b1;
                        if (op_read) begin
                            rdata       <= '0;
                            rdata_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OAM_WAIT: begin
                    if (!oam_busy) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_mem_port.md
Name: cpu_mem_port

Overview:
- Memory-side responder for the CPU data-access control signals (MemRead, MemWrite, OAMWrite) produced by the instruction decoder.
- Accepts one access per instruction from the MEM stage and stalls the pipeline while the access is outstanding.
- Routes the access either to data RAM, using a req/ack handshake, or to sprite OAM, gated by the PPU busy flag.
- Returns read data to the write-back path.

Parameters:
- ADDR_W, 16, CPU data address width.
- DATA_W, 32, data word width.
- OAM_ADDR_W, 8, OAM address width; taken from addr[OAM_ADDR_W-1:0].
- TIMEOUT, 16, maximum cycles to wait for ram_ack before aborting; must be at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read  in  1  read request from the decoder.
- mem_write  in  1  RAM write request from the decoder.
- oam_write  in  1  OAM write request from the decoder.
- addr  in  ADDR_W  access address.
- wdata  in  DATA_W  write data.
- stall  out  1  holds the pipeline (combinational).
- rdata  out  DATA_W  registered read data.
- rdata_valid  out  1  one-cycle pulse when rdata is valid.
- err  out  1  one-cycle pulse on an illegal request combination or a RAM timeout.
- ram_req  out  1  RAM request, held until acknowledged.
- ram_we  out  1  RAM write enable, qualified by ram_req.
- ram_addr  out  ADDR_W  latched address.
- ram_wdata  out  DATA_W  latched write data.
- ram_ack  in  1  RAM completion; read data is valid in the same cycle.
- ram_rdata  in  DATA_W  RAM read data.
- oam_busy  in  1  PPU is reading OAM; writes are forbidden while high.
- oam_we  out  1  one-cycle OAM write strobe.
- oam_addr  out  OAM_ADDR_W  OAM address.
- oam_wdata  out  DATA_W  OAM write data.

Behaviour:
- Reset: every output is 0, state = IDLE, timeout counter = 0, latched address/data = 0. Reset is effective immediately at any point (see last bullet).
- Request: req = mem_read | mem_write | oam_write. The request is sampled only in IDLE.
- Request priority when more than one strobe is high:
  - oam_write wins over mem_write, which wins over mem_read.
  - err pulses in the cycle after acceptance.
- State machine:
  - IDLE:
    - No req: stay in IDLE.
    - req: latch addr and wdata, select the operation. Go to OAM_WAIT for an OAM write, otherwise RAM_REQ.
  - RAM_REQ:
    - ram_req = 1; ram_we = 1 for a write.
    - ram_ack: capture ram_rdata into rdata (reads only), then go to DONE.
    - Timeout counter increments every RAM_REQ cycle without ack.
    - Counter reaches TIMEOUT-1 with no ack: go to DONE, err pulses, rdata = 0 (reads still pulse rdata_valid).
  - OAM_WAIT:
    - oam_busy = 1: wait indefinitely; no timeout applies.
    - oam_busy = 0: oam_we = 1 for exactly this cycle, then go to DONE.
    - If oam_busy rises in the same cycle, the write is deferred; the strobe is never issued while oam_busy is high.
  - DONE:
    - Lasts one cycle; stall = 0 and req is ignored.
    - rdata_valid = 1 for reads.
    - Timeout counter is cleared.
    - Go to IDLE unconditionally.
- Stall:
  - stall = (IDLE & req) | RAM_REQ | OAM_WAIT.
  - The pipeline holds the instruction, so the strobes remain asserted until DONE; the pipeline advances on the edge leaving DONE.
- Latency:
  - Read or write with ack in the first RAM_REQ cycle: stall is high for 2 cycles; rdata_valid is in the 3rd cycle from acceptance.
  - OAM write with oam_busy low: oam_we is in cycle 2; DONE is in cycle 3.
- ram_addr, ram_wdata, oam_addr and oam_wdata are registered copies of the latched values. They hold until the next acceptance.
- ram_ack outside RAM_REQ is ignored.
- rdata holds its value between reads.
- Reset mid-operation:
  - Any in-flight RAM request is abandoned and ram_req drops immediately.
  - No oam_we is issued.
  - The RAM side must tolerate a withdrawn request.

Test Plan:
- Read, addr=0x0040, ram_ack in the first RAM_REQ cycle with ram_rdata=0xDEADBEEF -> stall high for cycles 0-1; rdata=0xDEADBEEF with rdata_valid=1 in cycle 2; ram_we=0 throughout.
- Write, addr=0x0100, wdata=0x12345678, ram_ack after 3 wait cycles -> ram_req high for 4 cycles with ram_we=1 and ram_wdata=0x12345678; no rdata_valid; stall low in DONE.
- oam_write with addr=0x01A5 and oam_busy high for 5 cycles -> no oam_we while busy; exactly one oam_we with oam_addr=0xA5 in the first not-busy cycle; DONE follows.
- Read with ram_ack never asserted, TIMEOUT=16 -> DONE reached after 16 RAM_REQ cycles; err=1, rdata=0, rdata_valid=1; the next request is accepted normally.
- mem_read and oam_write both high -> OAM write is performed; err pulses once; no ram_req.
- rst_n low during RAM_REQ -> ram_req, stall and all other outputs go to 0 immediately; after release, a new read completes in the normal latency.
